// File: rtl/barrel_fetch_unit_if.sv
// Fetch-side bus of the barrel core: imem port, execute redirect, stall, and fetch->decode slot.
// With THREAD_MASK_EN defined, the bus also carries a per-thread enable mask.
interface barrel_fetch_unit_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_THREADS   = 8
);
  localparam int BT = $clog2(NUM_THREADS);

  logic                     stall_f;
  logic                     redirect_valid_e;
  logic [BT-1:0]            redirect_tid_e;
  logic [ADDRESS_WIDTH-1:0] redirect_pc_e;
  logic [ADDRESS_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0]    imem_rdata;
  logic [ADDRESS_WIDTH-1:0] pc_f;
  logic [ADDRESS_WIDTH-1:0] pc_plus4_f;
  logic [DATA_WIDTH-1:0]    instr_f;
  logic [BT-1:0]            tid_f;
  logic                     fetch_valid_f;
`ifdef THREAD_MASK_EN
  logic [NUM_THREADS-1:0]   thread_en;

  modport master (
    input  stall_f, redirect_valid_e, redirect_tid_e, redirect_pc_e, imem_rdata, thread_en,
    output imem_addr, pc_f, pc_plus4_f, instr_f, tid_f, fetch_valid_f
  );
  modport slave (
    output stall_f, redirect_valid_e, redirect_tid_e, redirect_pc_e, imem_rdata, thread_en,
    input  imem_addr, pc_f, pc_plus4_f, instr_f, tid_f, fetch_valid_f
  );
`else
  modport master (
    input  stall_f, redirect_valid_e, redirect_tid_e, redirect_pc_e, imem_rdata,
    output imem_addr, pc_f, pc_plus4_f, instr_f, tid_f, fetch_valid_f
  );
  modport slave (
    output stall_f, redirect_valid_e, redirect_tid_e, redirect_pc_e, imem_rdata,
    input  imem_addr, pc_f, pc_plus4_f, instr_f, tid_f, fetch_valid_f
  );
`endif
endinterface

// File: rtl/barrel_fetch_unit.sv
// Barrel fetch stage: one PC per hardware thread, round-robin thread select, execute redirects.
// Optional THREAD_MASK_EN adds a per-thread enable that idles a slot without changing the cadence.
module barrel_fetch_unit #(
  parameter int                     ADDRESS_WIDTH = 32,
  parameter int                     DATA_WIDTH    = 32,
  parameter int                     NUM_THREADS   = 8,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0,
  parameter logic [ADDRESS_WIDTH-1:0] THREAD_STRIDE = '0
) (
  input  logic                clk,
  input  logic                rst,
  barrel_fetch_unit_if.master bus
);
  localparam int BT = $clog2(NUM_THREADS);
  localparam logic [BT-1:0] LAST_TID = BT'(NUM_THREADS - 1);

  logic [ADDRESS_WIDTH-1:0] pc_file [NUM_THREADS];
  logic [BT-1:0]            tid_cnt;
  logic [ADDRESS_WIDTH-1:0] pc_sel;
  logic [ADDRESS_WIDTH-1:0] pc_next;
  logic                     thread_active;
  logic                     redirect_hit;
  logic [ADDRESS_WIDTH-1:0] redirect_pc_aligned;

  // Start PC of thread i, wrapping modulo 2^ADDRESS_WIDTH.
  function automatic logic [ADDRESS_WIDTH-1:0] start_pc(input int idx);
    logic [ADDRESS_WIDTH-1:0] i_w;
    i_w = ADDRESS_WIDTH'(idx);
    return RESET_PC + THREAD_STRIDE * i_w;
  endfunction

  assign pc_sel  = pc_file[tid_cnt];
  assign pc_next = pc_sel + ADDRESS_WIDTH'(4);

`ifdef THREAD_MASK_EN
  assign thread_active = bus.thread_en[tid_cnt];
`else
  assign thread_active = 1'b1;
`endif

  // Out-of-range thread ids (possible when NUM_THREADS is not a power of two) are dropped.
  assign redirect_hit        = bus.redirect_valid_e && (32'(bus.redirect_tid_e) < NUM_THREADS);
  assign redirect_pc_aligned = {bus.redirect_pc_e[ADDRESS_WIDTH-1:2], 2'b00};

  assign bus.tid_f         = tid_cnt;
  assign bus.pc_f          = pc_sel;
  assign bus.imem_addr     = pc_sel;
  assign bus.pc_plus4_f    = pc_next;
  assign bus.instr_f       = bus.imem_rdata;
  assign bus.fetch_valid_f = !rst && !bus.stall_f && thread_active;

  // The redirect write comes last so it overrides the +4 update of the same thread.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_THREADS; i++) begin
        pc_file[i] <= start_pc(i);
      end
      tid_cnt <= '0;
    end else begin
      if (!bus.stall_f) begin
        if (thread_active) begin
          pc_file[tid_cnt] <= pc_next;
        end
        tid_cnt <= (tid_cnt == LAST_TID) ? '0 : tid_cnt + 1'b1;
      end
      if (redirect_hit) begin
        pc_file[bus.redirect_tid_e] <= redirect_pc_aligned;
      end
    end
  end
endmodule

// File: tb/tb_barrel_fetch_unit.sv
// Directed bench for barrel_fetch_unit: an 8-thread and a 6-thread instance driven from vector tables.
// The thread-mask sequence is compiled in only when THREAD_MASK_EN is defined.
module tb_barrel_fetch_unit;
  typedef struct {
    logic        rst;
    logic        stall;
    logic        rv;
    logic [2:0]  rtid;
    logic [31:0] rpc;
    logic [2:0]  etid;
    logic [31:0] epc;
    logic        evalid;
  } vec_t;

  logic clk = 1'b0;
  logic rst8;
  logic rst6;
  int   checks = 0;
  int   failures = 0;
  vec_t v8[$];
  vec_t v6[$];

  always #5 clk = ~clk;

  barrel_fetch_unit_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .NUM_THREADS(8)) bus8 ();
  barrel_fetch_unit_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .NUM_THREADS(6)) bus6 ();

  barrel_fetch_unit #(
    .ADDRESS_WIDTH(32), .DATA_WIDTH(32), .NUM_THREADS(8),
    .RESET_PC(32'h1000), .THREAD_STRIDE(32'h100)
  ) dut8 (.clk(clk), .rst(rst8), .bus(bus8.master));

  barrel_fetch_unit #(
    .ADDRESS_WIDTH(32), .DATA_WIDTH(32), .NUM_THREADS(6),
    .RESET_PC(32'h0), .THREAD_STRIDE(32'h40)
  ) dut6 (.clk(clk), .rst(rst6), .bus(bus6.master));

  // Instruction memory stand-in: a fixed scramble of the address.
  function automatic logic [31:0] imem_model(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  assign bus8.imem_rdata = imem_model(bus8.imem_addr);
  assign bus6.imem_rdata = imem_model(bus6.imem_addr);

  function automatic vec_t mk(input logic r, input logic s, input logic rv, input logic [2:0] rtid,
                              input logic [31:0] rpc, input logic [2:0] etid,
                              input logic [31:0] epc, input logic ev);
    vec_t v;
    v.rst = r; v.stall = s; v.rv = rv; v.rtid = rtid; v.rpc = rpc;
    v.etid = etid; v.epc = epc; v.evalid = ev;
    return v;
  endfunction

  task automatic cmp(input string name, input int row, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s row %0d: got %h expected %h", name, row, got, exp);
    end
  endtask

  task automatic applyStimulus(input int sel, input vec_t v);
    if (sel == 0) begin
      rst8 = v.rst;
      bus8.stall_f = v.stall;
      bus8.redirect_valid_e = v.rv;
      bus8.redirect_tid_e = v.rtid;
      bus8.redirect_pc_e = v.rpc;
    end else begin
      rst6 = v.rst;
      bus6.stall_f = v.stall;
      bus6.redirect_valid_e = v.rv;
      bus6.redirect_tid_e = v.rtid;
      bus6.redirect_pc_e = v.rpc;
    end
  endtask

  task automatic checkOutput(input int sel, input int row, input vec_t v);
    logic [2:0]  tid;
    logic [31:0] pc, addr, pc4, instr;
    logic        valid;
    if (sel == 0) begin
      tid = bus8.tid_f; pc = bus8.pc_f; addr = bus8.imem_addr;
      pc4 = bus8.pc_plus4_f; instr = bus8.instr_f; valid = bus8.fetch_valid_f;
    end else begin
      tid = bus6.tid_f; pc = bus6.pc_f; addr = bus6.imem_addr;
      pc4 = bus6.pc_plus4_f; instr = bus6.instr_f; valid = bus6.fetch_valid_f;
    end
    cmp(sel == 0 ? "t8_tid" : "t6_tid", row, 32'(tid), 32'(v.etid));
    cmp(sel == 0 ? "t8_pc" : "t6_pc", row, pc, v.epc);
    cmp(sel == 0 ? "t8_addr" : "t6_addr", row, addr, v.epc);
    cmp(sel == 0 ? "t8_pc4" : "t6_pc4", row, pc4, v.epc + 32'd4);
    cmp(sel == 0 ? "t8_instr" : "t6_instr", row, instr, imem_model(v.epc));
    cmp(sel == 0 ? "t8_valid" : "t6_valid", row, 32'(valid), 32'(v.evalid));
  endtask

  task automatic runTable(input int sel);
    int n;
    vec_t v;
    n = (sel == 0) ? v8.size() : v6.size();
    for (int i = 0; i < n; i++) begin
      v = (sel == 0) ? v8[i] : v6[i];
      applyStimulus(sel, v);
      #1;
      checkOutput(sel, i, v);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst8 = 1'b1;
    rst6 = 1'b1;
    bus8.stall_f = 1'b0; bus8.redirect_valid_e = 1'b0;
    bus8.redirect_tid_e = '0; bus8.redirect_pc_e = '0;
    bus6.stall_f = 1'b0; bus6.redirect_valid_e = 1'b0;
    bus6.redirect_tid_e = '0; bus6.redirect_pc_e = '0;
`ifdef THREAD_MASK_EN
    bus8.thread_en = 8'hFF;
    bus6.thread_en = 6'h3F;
`endif

    // 8 threads, RESET_PC 0x1000, stride 0x100; redirect 0x2003 to thread 2 arrives when 2 is selected.
    v8.push_back(mk(1, 0, 1, 3'd4, 32'h9000, 3'd0, 32'h1000, 0));
    for (int i = 0; i < 8; i++) v8.push_back(mk(0, 0, 0, 3'd0, 32'h0, 3'(i), 32'h1000 + 32'h100 * i, 1));
    v8.push_back(mk(0, 0, 0, 3'd0, 32'h0,    3'd0, 32'h1004, 1));
    v8.push_back(mk(0, 0, 0, 3'd0, 32'h0,    3'd1, 32'h1104, 1));
    v8.push_back(mk(0, 0, 1, 3'd2, 32'h2003, 3'd2, 32'h1204, 1));
    v8.push_back(mk(0, 0, 0, 3'd0, 32'h0,    3'd3, 32'h1304, 1));
    v8.push_back(mk(0, 0, 0, 3'd0, 32'h0,    3'd4, 32'h1404, 1));
    v8.push_back(mk(0, 1, 1, 3'd6, 32'h3000, 3'd5, 32'h1504, 0));
    v8.push_back(mk(0, 1, 0, 3'd0, 32'h0,    3'd5, 32'h1504, 0));
    v8.push_back(mk(0, 1, 0, 3'd0, 32'h0,    3'd5, 32'h1504, 0));
    v8.push_back(mk(0, 0, 0, 3'd0, 32'h0,    3'd5, 32'h1504, 1));
    v8.push_back(mk(0, 0, 0, 3'd0, 32'h0,    3'd6, 32'h3000, 1));
    v8.push_back(mk(0, 0, 0, 3'd0, 32'h0,    3'd7, 32'h1704, 1));
    v8.push_back(mk(0, 0, 0, 3'd0, 32'h0,    3'd0, 32'h1008, 1));
    v8.push_back(mk(0, 0, 0, 3'd0, 32'h0,    3'd1, 32'h1108, 1));
    v8.push_back(mk(0, 0, 0, 3'd0, 32'h0,    3'd2, 32'h2000, 1));
    v8.push_back(mk(0, 0, 0, 3'd0, 32'h0,    3'd3, 32'h1308, 1));

    // 6 threads, RESET_PC 0, stride 0x40; PC wrap at 0xFFFFFFFC, out-of-range redirects, mid-run reset.
    v6.push_back(mk(1, 0, 0, 3'd0, 32'h0, 3'd0, 32'h0, 0));
    for (int i = 0; i < 6; i++) v6.push_back(mk(0, 0, 0, 3'd0, 32'h0, 3'(i), 32'h40 * i, 1));
    v6.push_back(mk(0, 0, 1, 3'd1, 32'hFFFF_FFFE, 3'd0, 32'h4,         1));
    v6.push_back(mk(0, 0, 1, 3'd7, 32'h5000,      3'd1, 32'hFFFF_FFFC, 1));
    v6.push_back(mk(0, 0, 0, 3'd0, 32'h0,         3'd2, 32'h84,        1));
    v6.push_back(mk(0, 0, 1, 3'd6, 32'h6000,      3'd3, 32'hC4,        1));
    v6.push_back(mk(0, 0, 0, 3'd0, 32'h0,         3'd4, 32'h104,       1));
    v6.push_back(mk(0, 0, 0, 3'd0, 32'h0,         3'd5, 32'h144,       1));
    v6.push_back(mk(0, 0, 0, 3'd0, 32'h0,         3'd0, 32'h8,         1));
    v6.push_back(mk(0, 0, 0, 3'd0, 32'h0,         3'd1, 32'h0,         1));
    v6.push_back(mk(1, 0, 1, 3'd3, 32'h7000,      3'd2, 32'h88,        0));
    for (int i = 0; i < 6; i++) v6.push_back(mk(0, 0, 0, 3'd0, 32'h0, 3'(i), 32'h40 * i, 1));
    v6.push_back(mk(0, 0, 0, 3'd0, 32'h0,         3'd0, 32'h4,         1));

    repeat (2) @(posedge clk);
    #1;
    runTable(0);
    runTable(1);

`ifdef THREAD_MASK_EN
    // Thread 2 disabled: its slot stays in the rotation but never fetches or advances.
    begin
      logic [31:0] exp_pc [8];
      logic [7:0]  en;
      en = 8'b1111_1011;
      for (int t = 0; t < 8; t++) exp_pc[t] = 32'h1000 + 32'h100 * t;
      rst8 = 1'b1;
      bus8.stall_f = 1'b0;
      bus8.redirect_valid_e = 1'b0;
      bus8.thread_en = en;
      @(posedge clk);
      #1;
      rst8 = 1'b0;
      for (int c = 0; c < 20; c++) begin
        #1;
        cmp("mask_tid", c, 32'(bus8.tid_f), 32'(c % 8));
        cmp("mask_pc", c, bus8.pc_f, exp_pc[c % 8]);
        cmp("mask_valid", c, 32'(bus8.fetch_valid_f), 32'(en[c % 8]));
        if (en[c % 8]) exp_pc[c % 8] = exp_pc[c % 8] + 32'd4;
        @(posedge clk);
        #1;
      end
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
